// File: rtl/addr_step_counter.sv
// Registered address accumulator: each RUN cycle adds STEP to ADDR via a chain of 4-bit
// ripple-carry slices while an inner-loop count runs down. Optional feature macro: ADDR_DEC_EN (adds DIR / subtract).
module addr_step_counter #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 10
) (
    input  logic                 CLK,
    input  logic                 RESETL,
    input  logic                 LOAD,
    input  logic [WIDTH-1:0]     LDATA,
    input  logic [WIDTH-1:0]     STEP,
    input  logic [CNT_WIDTH-1:0] CNT,
    input  logic                 START,
    input  logic                 HOLD,
`ifdef ADDR_DEC_EN
    input  logic                 DIR,
`endif
    output logic [WIDTH-1:0]     ADDR,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 CARRY
);

    localparam int NSLICE = WIDTH / 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       addr_q, addr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   carry_q, carry_d;

    logic [WIDTH-1:0]       y_op;
    logic [WIDTH-1:0]       sum;
    logic [NSLICE:0]        slice_c;

`ifdef ADDR_DEC_EN
    // Subtraction reuses the adder as ADDR + ~STEP + 1; CARRY then reads as "no borrow".
    assign y_op       = DIR ? ~STEP : STEP;
    assign slice_c[0] = DIR;
`else
    assign y_op       = STEP;
    assign slice_c[0] = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi = gi + 1) begin : g_slice
            logic [4:0] slice_sum;
            assign slice_sum = {1'b0, addr_q[gi*4 +: 4]} + {1'b0, y_op[gi*4 +: 4]}
                             + {4'b0000, slice_c[gi]};
            assign sum[gi*4 +: 4] = slice_sum[3:0];
            assign slice_c[gi+1]  = slice_sum[4];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        case (state_q)
            S_IDLE: begin
                if (LOAD) begin
                    addr_d = LDATA;
                end
                if (START) begin
                    cnt_d   = CNT;
                    state_d = (CNT == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (!HOLD) begin
                    addr_d  = sum;
                    carry_d = slice_c[NSLICE];
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETL) begin
        if (!RESETL) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    assign ADDR  = addr_q;
    assign CARRY = carry_q;
    assign BUSY  = (state_q == S_RUN);
    assign DONE  = (state_q == S_DONE);

endmodule

// File: tb/tb_addr_step_counter.sv
// Self-checking bench for addr_step_counter: vector table, hand-written corner sequences
// and randomized runs against an arithmetic reference model.
module tb_addr_step_counter;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] ldata;
    logic [15:0] step;
    logic [9:0]  cnt;
    logic        start;
    logic        hold;
    logic        dir;
    logic [15:0] addr;
    logic        busy;
    logic        done;
    logic        carry;

    int n_checks = 0;
    int n_fail   = 0;

    addr_step_counter #(.WIDTH(16), .CNT_WIDTH(10)) dut (
        .CLK    (clk),
        .RESETL (rst_n),
        .LOAD   (load),
        .LDATA  (ldata),
        .STEP   (step),
        .CNT    (cnt),
        .START  (start),
        .HOLD   (hold),
`ifdef ADDR_DEC_EN
        .DIR    (dir),
`endif
        .ADDR   (addr),
        .BUSY   (busy),
        .DONE   (done),
        .CARRY  (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ldata;
        logic [15:0] step;
        logic [9:0]  cnt;
        logic [15:0] exp_addr;
        logic        exp_carry;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d);
        load  = 1'b1;
        ldata = d;
        tick();
        load  = 1'b0;
    endtask

    // Starts a run and follows it to the DONE pulse with optional random stalls.
    task automatic do_run(input logic [15:0] s, input logic [9:0] c, input int hold_pct,
                          output int busy_cycles, output int holds, output bit got_done);
        step  = s;
        cnt   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_cycles = 0;
        holds = 0;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) begin
                busy_cycles++;
                hold = ($urandom_range(99) < hold_pct) ? 1'b1 : 1'b0;
                if (hold) holds++;
            end
            tick();
        end
        hold = 1'b0;
    endtask

    // Reference: repeated N-fold addition with 17-bit arithmetic; carry is from the last add.
    function automatic logic [16:0] model_run(input logic [15:0] a0, input logic [15:0] s,
                                              input int n, input logic c0);
        logic [16:0] t;
        logic [15:0] a;
        logic        c;
        a = a0;
        c = c0;
        for (int i = 0; i < n; i++) begin
            t = {1'b0, a} + {1'b0, s};
            a = t[15:0];
            c = t[16];
        end
        return {c, a};
    endfunction

    initial begin
        int bc, hc;
        bit gd;
        logic [16:0] m;
        logic model_carry;
        int done_seen;
        logic [15:0] rl;
        logic [15:0] rs;
        int rc;

        vecs[0] = '{16'h1000, 16'h0010, 10'd4, 16'h1040, 1'b0};
        vecs[1] = '{16'h0FFF, 16'h0001, 10'd1, 16'h1000, 1'b0};
        vecs[2] = '{16'h0000, 16'hFFFF, 10'd2, 16'hFFFE, 1'b1};
        vecs[3] = '{16'h8000, 16'h4000, 10'd3, 16'h4000, 1'b0};
        vecs[4] = '{16'hFFF0, 16'h0020, 10'd1, 16'h0010, 1'b1};

        rst_n = 1'b0; load = 0; ldata = 0; step = 0; cnt = 0; start = 0; hold = 0; dir = 0;
        #1;
        check("reset_addr", 32'(addr), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_carry", 32'(carry), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Vector table
        foreach (vecs[i]) begin
            do_load(vecs[i].ldata);
            do_run(vecs[i].step, vecs[i].cnt, 0, bc, hc, gd);
            check($sformatf("vec%0d_done", i), 32'(gd), 32'h1);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_addr", i), 32'(addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].exp_carry));
            tick();
            check($sformatf("vec%0d_done_one_cycle", i), 32'(done), 32'h0);
        end

        // CARRY survives LOAD
        do_load(16'h0ABC);
        check("load_keeps_carry", 32'(carry), 32'h1);

        // Basic run, cycle by cycle
        do_load(16'h1000);
        step = 16'h0010; cnt = 10'd4; start = 1'b1;
        tick();
        start = 1'b0;
        check("basic_busy_after_start", 32'(busy), 32'h1);
        check("basic_addr_after_start", 32'(addr), 32'h1000);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("basic_addr_%0d", k), 32'(addr), 32'(16'h1000 + 16'h0010 * k));
            check($sformatf("basic_busy_%0d", k), 32'(busy), 32'(k < 4));
            check($sformatf("basic_done_%0d", k), 32'(done), 32'(k == 4));
        end
        tick();
        check("basic_done_cleared", 32'(done), 32'h0);

        // HOLD for two cycles after the first add
        do_load(16'h0000);
        step = 16'h0001; cnt = 10'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("hold_first_add", 32'(addr), 32'h1);
        hold = 1'b1;
        tick();
        check("hold_frozen_1", 32'(addr), 32'h1);
        check("hold_busy_1", 32'(busy), 32'h1);
        tick();
        check("hold_frozen_2", 32'(addr), 32'h1);
        hold = 1'b0;
        tick();
        check("hold_addr_2", 32'(addr), 32'h2);
        check("hold_no_early_done", 32'(done), 32'h0);
        tick();
        check("hold_addr_3", 32'(addr), 32'h3);
        check("hold_done_delayed", 32'(done), 32'h1);
        tick();

        // START with CNT=0
        do_load(16'h1234);
        step = 16'h0101; cnt = 10'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("cnt0_done", 32'(done), 32'h1);
        check("cnt0_busy", 32'(busy), 32'h0);
        check("cnt0_addr", 32'(addr), 32'h1234);
        tick();
        check("cnt0_done_cleared", 32'(done), 32'h0);

        // LOAD and START together
        load = 1'b1; ldata = 16'h2000; start = 1'b1; step = 16'h0001; cnt = 10'd2;
        tick();
        load = 1'b0; start = 1'b0;
        tick();
        tick();
        check("ldst_addr", 32'(addr), 32'h2002);
        check("ldst_done", 32'(done), 32'h1);
        tick();

        // LOAD during RUN is ignored
        step = 16'h0001; cnt = 10'd3; start = 1'b1;
        tick();
        start = 1'b0; load = 1'b1; ldata = 16'hBEEF;
        tick(); tick(); tick();
        check("load_in_run_addr", 32'(addr), 32'h2005);
        load = 1'b0;
        tick();

        // Randomized runs with random stalls
        model_carry = carry;
        for (int it = 0; it < 25; it++) begin
            rl = 16'($urandom);
            rs = 16'($urandom);
            rc = $urandom_range(7);
            do_load(rl);
            do_run(rs, 10'(rc), 30, bc, hc, gd);
            m = model_run(rl, rs, rc, model_carry);
            model_carry = m[16];
            check($sformatf("rand%0d_done", it), 32'(gd), 32'h1);
            check($sformatf("rand%0d_addr", it), 32'(addr), 32'(m[15:0]));
            check($sformatf("rand%0d_carry", it), 32'(carry), 32'(m[16]));
            check($sformatf("rand%0d_adds", it), 32'(bc - hc), 32'(rc));
            tick();
        end

`ifdef ADDR_DEC_EN
        do_load(16'h0005);
        dir = 1'b1; step = 16'h0003; cnt = 10'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("dec_addr_1", 32'(addr), 32'h0002);
        check("dec_carry_1", 32'(carry), 32'h1);
        tick();
        check("dec_addr_2", 32'(addr), 32'hFFFF);
        check("dec_carry_2", 32'(carry), 32'h0);
        dir = 1'b0;
        tick();
`endif

        // Reset asserted mid-run aborts without a DONE pulse
        do_load(16'hFFF0);
        do_run(16'h0020, 10'd1, 0, bc, hc, gd);
        tick();
        step = 16'h0001; cnt = 10'd10; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check("midrun_busy_before_reset", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_addr", 32'(addr), 32'h0);
        check("midrun_reset_busy", 32'(busy), 32'h0);
        check("midrun_reset_carry", 32'(carry), 32'h0);
        tick();
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done || busy) done_seen++;
        end
        check("midrun_no_done_after_release", 32'(done_seen), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
